// File: rtl/frame_dispatcher.sv
// Round-robin frame dispatcher: grants each upstream frame to a free image processor and meters its beats.
// Optional stall abort is compiled in with `define FRAME_DISPATCH_TIMEOUT_EN.
module frame_dispatcher #(
  parameter int unsigned IP_AMT      = 4,
  parameter int unsigned IP_ADDR_W   = 2,
  parameter int unsigned PGROUP_NUM  = 2400,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_req_i,
  output logic                 frame_gnt_o,
  output logic [IP_ADDR_W-1:0] frame_dest_o,
  output logic                 stream_en_o,
  input  logic                 pgroup_valid_i,
  input  logic                 pgroup_ready_i,
  input  logic [IP_AMT-1:0]    ip_done_i,
  output logic [IP_AMT-1:0]    ip_busy_o,
  output logic                 frame_sent_o,
  output logic                 err_timeout_o
);

  localparam int unsigned CNT_W = $clog2(PGROUP_NUM + 1);

  if (PGROUP_NUM < 1 || TIMEOUT_CYC < 1 || (1 << IP_ADDR_W) < IP_AMT) begin : g_bad_params
    $error("frame_dispatcher: inconsistent parameters");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_STREAM} state_t;

  state_t               state, state_n;
  logic [IP_ADDR_W-1:0] last_dest, last_dest_n, dest_q, dest_n, sel_dest;
  logic                 sel_found;
  logic [IP_AMT-1:0]    busy, busy_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic                 hs, last_beat, timeout;

  assign hs           = pgroup_valid_i & pgroup_ready_i;
  assign last_beat    = (cnt == CNT_W'(PGROUP_NUM - 1));
  assign frame_dest_o = dest_q;
  assign ip_busy_o    = busy;

`ifdef FRAME_DISPATCH_TIMEOUT_EN
  localparam int unsigned STALL_W = $clog2(TIMEOUT_CYC + 1);
  logic [STALL_W-1:0] stall;

  // Fires on the TIMEOUT_CYC-th consecutive STREAM cycle without a handshake.
  assign timeout       = (state == ST_STREAM) && !hs && (stall == STALL_W'(TIMEOUT_CYC - 1));
  assign err_timeout_o = timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    stall <= '0;
    else if (state != ST_STREAM || hs || timeout) stall <= '0;
    else                                        stall <= stall + STALL_W'(1);
  end
`else
  assign timeout       = 1'b0;
  assign err_timeout_o = 1'b0;
`endif

  // First free processor above the previous destination, wrapping.
  always_comb begin
    int unsigned          idx;
    logic [IP_ADDR_W-1:0] idx_w;
    sel_found = 1'b0;
    sel_dest  = '0;
    idx       = 0;
    idx_w     = '0;
    for (int unsigned i = 1; i <= IP_AMT; i++) begin
      idx   = (32'(last_dest) + i) % IP_AMT;
      idx_w = IP_ADDR_W'(idx);
      if (!sel_found && !busy[idx_w]) begin
        sel_found = 1'b1;
        sel_dest  = idx_w;
      end
    end
  end

  always_comb begin
    state_n      = state;
    dest_n       = dest_q;
    last_dest_n  = last_dest;
    busy_n       = busy & ~ip_done_i;
    cnt_n        = cnt;
    frame_gnt_o  = 1'b0;
    stream_en_o  = 1'b0;
    frame_sent_o = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // Grant bookkeeping is registered on entry so it is already visible during GRANT;
        // the set is applied after the done-clear so a coincident done loses.
        if (frame_req_i && sel_found) begin
          state_n          = ST_GRANT;
          dest_n           = sel_dest;
          last_dest_n      = sel_dest;
          busy_n[sel_dest] = 1'b1;
        end
      end
      ST_GRANT: begin
        frame_gnt_o = 1'b1;
        state_n     = ST_STREAM;
      end
      ST_STREAM: begin
        stream_en_o = 1'b1;
        if (hs) begin
          if (last_beat) begin
            frame_sent_o = 1'b1;
            cnt_n        = '0;
            state_n      = ST_IDLE;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end else if (timeout) begin
          busy_n[dest_q] = 1'b0;
          cnt_n          = '0;
          state_n        = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      dest_q    <= '0;
      last_dest <= IP_ADDR_W'(IP_AMT - 1);
      busy      <= '0;
      cnt       <= '0;
    end else begin
      state     <= state_n;
      dest_q    <= dest_n;
      last_dest <= last_dest_n;
      busy      <= busy_n;
      cnt       <= cnt_n;
    end
  end

endmodule
